store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 30 +++
 rtl/store_buffer.sv | 90 +++++++++
 tb/tb_store_buffer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Core-to-store-buffer-to-memory handshake bundle, including the load
// forwarding lookup.
interface store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          MemWrite;
  logic [AW-1:0] DataAdr;
  logic [DW-1:0] WriteData;
  logic          stall;
  logic          mem_valid;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [AW-1:0] ld_adr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          empty;

  // master: the core/memory side that drives requests and observes the buffer
  modport master (
    output MemWrite, DataAdr, WriteData, mem_ready, ld_adr,
    input  stall, mem_valid, mem_adr, mem_wdata, fwd_hit, fwd_data, empty
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, mem_ready, ld_adr,
    output stall, mem_valid, mem_adr, mem_wdata, fwd_hit, fwd_data, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer between the core and data memory, with combinational
// youngest-match load forwarding over the buffered entries.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [AW-1:0] adr_q  [DEPTH];
  logic [AW-1:0] adr_d  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];

  logic          full;
  logic          push;
  logic          pop;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic [PW-1:0] idx;

  always_comb begin
    full    = (count_q == FULL_CNT);
    push    = sb.MemWrite & ~full;
    pop     = (count_q != '0) & sb.mem_ready;
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    adr_d  = adr_q;
    data_d = data_q;
    if (push) begin
      adr_d[tail_q]  = sb.DataAdr;
      data_d[tail_q] = sb.WriteData;
    end
  end

  // Scan oldest to youngest so the last match wins; the entry being pushed
  // this cycle is not yet counted, the one being popped still is.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (adr_q[idx] == sb.ld_adr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: only entries inside the count are observed.
  always_ff @(posedge clk) begin
    adr_q  <= adr_d;
    data_q <= data_d;
  end

  assign sb.stall     = sb.MemWrite & full;
  assign sb.mem_valid = (count_q != '0);
  assign sb.empty     = (count_q == '0);
  assign sb.mem_adr   = sb.mem_valid ? adr_q[head_q]  : '0;
  assign sb.mem_wdata = sb.mem_valid ? data_q[head_q] : '0;
  assign sb.fwd_hit   = hit;
  assign sb.fwd_data  = hit_data;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  ent_t          q[$];
  logic [AW-1:0] drained[$];
  logic [AW-1:0] pushed[$];

  store_buffer_if #(.AW(AW), .DW(DW)) sb ();

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO of accepted stores, updated with the pre-edge inputs.
  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
    end else begin
      automatic bit do_push = sb.MemWrite && (q.size() < DEPTH);
      if (q.size() != 0 && sb.mem_ready) void'(q.pop_front());
      if (do_push) q.push_back('{adr: sb.DataAdr, data: sb.WriteData});
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      automatic logic          e_hit = 1'b0;
      automatic logic [DW-1:0] e_fwd = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].adr == sb.ld_adr) begin
          e_hit = 1'b1;
          e_fwd = q[i].data;
          break;
        end
      end
      chk("m_stall",  sb.stall,     sb.MemWrite && (q.size() == DEPTH));
      chk("m_valid",  sb.mem_valid, q.size() != 0);
      chk("m_empty",  sb.empty,     q.size() == 0);
      chk("m_adr",    sb.mem_adr,   q.size() != 0 ? q[0].adr  : '0);
      chk("m_wdata",  sb.mem_wdata, q.size() != 0 ? q[0].data : '0);
      chk("m_fhit",   sb.fwd_hit,   e_hit);
      chk("m_fdata",  sb.fwd_data,  e_fwd);
      if (reset && sb.mem_valid && sb.mem_ready) drained.push_back(sb.mem_adr);
    end
  end

  initial begin
    int cyc;
    sb.MemWrite  = 1'b0;
    sb.DataAdr   = '0;
    sb.WriteData = '0;
    sb.mem_ready = 1'b0;
    sb.ld_adr    = '0;
    reset        = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_empty", sb.empty, 1'b1);
    chk("rst_valid", sb.mem_valid, 1'b0);
    chk("rst_adr", sb.mem_adr, 0);
    chk("rst_fhit", sb.fwd_hit, 1'b0);
    chk("rst_stall", sb.stall, 1'b0);

    // single store with immediate memory acceptance
    tick();
    sb.MemWrite = 1'b1; sb.DataAdr = 100; sb.WriteData = 25; sb.mem_ready = 1'b1;
    @(negedge clk);
    chk("single_nobypass", sb.mem_valid, 1'b0);
    tick();
    sb.MemWrite = 1'b0;
    @(negedge clk);
    chk("single_valid", sb.mem_valid, 1'b1);
    chk("single_adr", sb.mem_adr, 100);
    chk("single_data", sb.mem_wdata, 25);
    tick();
    @(negedge clk);
    chk("single_empty", sb.empty, 1'b1);

    // fill to full, fifth store stalls and is held
    tick();
    sb.mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sb.MemWrite = 1'b1; sb.DataAdr = 4 * k; sb.WriteData = k + 1;
      @(negedge clk);
      chk("fill_nostall", sb.stall, 1'b0);
      tick();
    end
    sb.DataAdr = 16; sb.WriteData = 5;
    @(negedge clk);
    chk("fill_stall", sb.stall, 1'b1);
    tick();
    sb.mem_ready = 1'b1;
    @(negedge clk);
    chk("stall_pop_same_cycle", sb.stall, 1'b1);
    chk("drain0", sb.mem_adr, 0);
    tick();
    @(negedge clk);
    chk("held_accepted", sb.stall, 1'b0);
    chk("drain4", sb.mem_adr, 4);
    tick();
    sb.MemWrite = 1'b0;
    @(negedge clk);
    chk("drain8", sb.mem_adr, 8);
    tick();
    @(negedge clk);
    chk("drain12", sb.mem_adr, 12);
    tick();
    @(negedge clk);
    chk("drain16", sb.mem_adr, 16);
    chk("drain16_data", sb.mem_wdata, 5);
    tick();
    @(negedge clk);
    chk("fill_empty", sb.empty, 1'b1);

    // forwarding: youngest match, pushed-this-cycle not visible
    tick();
    sb.mem_ready = 1'b0; sb.ld_adr = 96;
    sb.MemWrite = 1'b1; sb.DataAdr = 96; sb.WriteData = 7;
    @(negedge clk);
    chk("fwd_not_yet", sb.fwd_hit, 1'b0);
    tick();
    sb.WriteData = 9;
    @(negedge clk);
    chk("fwd_old_only", sb.fwd_data, 7);
    tick();
    sb.MemWrite = 1'b0;
    @(negedge clk);
    chk("fwd_hit", sb.fwd_hit, 1'b1);
    chk("fwd_young", sb.fwd_data, 9);
    tick();
    sb.ld_adr = 100;
    @(negedge clk);
    chk("fwd_miss_hit", sb.fwd_hit, 1'b0);
    chk("fwd_miss_data", sb.fwd_data, 0);
    tick();
    sb.ld_adr = 96; sb.mem_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("fwd_popping_still_hits", sb.fwd_data, 9);
    tick();
    @(negedge clk);
    chk("fwd_after_drain", sb.fwd_hit, 1'b0);

    // simultaneous push and pop at count 2
    tick();
    sb.mem_ready = 1'b0;
    sb.MemWrite = 1'b1; sb.DataAdr = 200; sb.WriteData = 1;
    tick();
    sb.DataAdr = 204; sb.WriteData = 2;
    tick();
    sb.DataAdr = 208; sb.WriteData = 3; sb.mem_ready = 1'b1;
    tick();
    sb.MemWrite = 1'b0; sb.mem_ready = 1'b0;
    @(negedge clk);
    chk("pp_count", dut.count_q, 2);
    chk("pp_model_size", q.size(), 2);
    chk("pp_head", sb.mem_adr, 204);
    sb.mem_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("pp_empty", sb.empty, 1'b1);

    // wrap-around with random memory backpressure
    tick();
    drained.delete();
    pushed.delete();
    cyc = 0;
    while ((pushed.size() < 10 || !sb.empty) && cyc < 300) begin
      if (!(sb.MemWrite && sb.stall)) begin
        sb.MemWrite = (pushed.size() < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
        sb.DataAdr   = 32'h1000 + 32'(pushed.size() * 4);
        sb.WriteData = 32'(pushed.size());
      end
      sb.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("wrap_count_le_depth", dut.count_q <= DEPTH, 1'b1);
      if (sb.MemWrite && !sb.stall) pushed.push_back(sb.DataAdr);
      tick();
      cyc++;
    end
    sb.MemWrite = 1'b0;
    chk("wrap_timeout", cyc < 300, 1'b1);
    chk("wrap_len", drained.size(), 10);
    for (int i = 0; i < 10 && i < drained.size() && i < pushed.size(); i++)
      chk("wrap_order", drained[i], 32'h1000 + 32'(i * 4));

    // reset during a drain discards everything
    sb.mem_ready = 1'b0;
    sb.MemWrite = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb.DataAdr = 300 + 4 * k; sb.WriteData = 40 + k;
      tick();
    end
    sb.MemWrite = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", sb.mem_valid, 1'b1);
    tick();
    reset = 1'b0; sb.mem_ready = 1'b1; sb.MemWrite = 1'b1; sb.DataAdr = 500;
    tick();
    reset = 1'b1; sb.MemWrite = 1'b0;
    @(negedge clk);
    chk("mid_rst_empty", sb.empty, 1'b1);
    chk("mid_rst_valid", sb.mem_valid, 1'b0);
    chk("mid_rst_adr", sb.mem_adr, 0);
    tick();
    tick();
    @(negedge clk);
    chk("mid_rst_stays_empty", sb.empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
